// File: rtl/asmi_prog_rx_if.sv
// Signal bundle between the Ethernet Rx payload path, the ASMI flash controller and the Tx replier.
// The slave modport is the asmi_prog_rx side; the master modport drives the environment side.
interface asmi_prog_rx_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        fifo_full;
  logic [7:0]  fifo_wdata;
  logic        fifo_wreq;
  logic        erase;
  logic        erase_ACK;
  logic [13:0] num_blocks;
  logic        erase_done;
  logic        erase_done_ACK;
  logic        send_more;
  logic        send_more_ACK;
  logic        reply_req;
  logic [1:0]  reply_code;
  logic        reply_ack;
  logic [2:0]  err_flags;

  modport slave (
    input  rx_data, rx_valid, rx_last, fifo_full, erase_ACK, erase_done, send_more, reply_ack,
    output fifo_wdata, fifo_wreq, erase, num_blocks, erase_done_ACK, send_more_ACK, reply_req,
           reply_code, err_flags
  );

  modport master (
    output rx_data, rx_valid, rx_last, fifo_full, erase_ACK, erase_done, send_more, reply_ack,
    input  fifo_wdata, fifo_wreq, erase, num_blocks, erase_done_ACK, send_more_ACK, reply_req,
           reply_code, err_flags
  );
endinterface

// File: rtl/asmi_prog_rx.sv
// Remote flash programming front end: parses EF FE 03 command frames into ASMI FIFO writes and
// erase requests, and converts controller erase_done/send_more levels into Tx reply requests.
module asmi_prog_rx (
  input  logic          clock,
  input  logic          reset_n,
  asmi_prog_rx_if.slave bus_io
);

  typedef enum logic [3:0] {
    StIdle, StH1, StH2, StCmd, StBlk0, StBlk1, StBlk2, StBlk3, StData, StDrain
  } parse_state_e;

  typedef enum logic [1:0] {RIdle, RReq, RAck} reply_state_e;

  parse_state_e st_q, st_d;
  reply_state_e r_q, r_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [5:0]   blk_q, blk_d;
  logic [13:0]  nb_q, nb_d;
  logic [2:0]   err_q, err_d;
  logic         wreq_q, wreq_d;
  logic [7:0]   wdata_q, wdata_d;
  logic         erase_q, erase_d;
  logic [1:0]   code_q, code_d;
  logic         src_level;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= StIdle;
      r_q     <= RIdle;
      cnt_q   <= '0;
      blk_q   <= '0;
      nb_q    <= '0;
      err_q   <= '0;
      wreq_q  <= 1'b0;
      wdata_q <= '0;
      erase_q <= 1'b0;
      code_q  <= '0;
    end else begin
      st_q    <= st_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      nb_q    <= nb_d;
      err_q   <= err_d;
      wreq_q  <= wreq_d;
      wdata_q <= wdata_d;
      erase_q <= erase_d;
      code_q  <= code_d;
    end
  end

  // Frame parser; every transition is qualified by rx_valid.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    nb_d    = nb_q;
    err_d   = err_q;
    wreq_d  = 1'b0;
    wdata_d = wdata_q;
    erase_d = erase_q & ~bus_io.erase_ACK;
    if (bus_io.rx_valid) begin
      wdata_d = bus_io.rx_data;
      case (st_q)
        StIdle: begin
          if (bus_io.rx_data == 8'hEF) st_d = StH1;
          else begin
            err_d[0] = 1'b1;
            st_d     = StDrain;
          end
        end
        StH1: begin
          if (bus_io.rx_data == 8'hFE) st_d = StH2;
          else begin
            err_d[0] = 1'b1;
            st_d     = StDrain;
          end
        end
        StH2: begin
          if (bus_io.rx_data == 8'h03) st_d = StCmd;
          else begin
            err_d[0] = 1'b1;
            st_d     = StDrain;
          end
        end
        StCmd: begin
          if (bus_io.rx_data == 8'h01) begin
            st_d  = StBlk0;
            cnt_d = '0;
          end else if (bus_io.rx_data == 8'h02) begin
            // A second erase while one is outstanding is dropped without side effects.
            if (!erase_q) begin
              erase_d = 1'b1;
              err_d   = '0;
            end
            st_d = StDrain;
          end else begin
            err_d[0] = 1'b1;
            st_d     = StDrain;
          end
        end
        StBlk0: st_d = StBlk1;
        StBlk1: st_d = StBlk2;
        StBlk2: begin
          blk_d = bus_io.rx_data[5:0];
          st_d  = StBlk3;
        end
        StBlk3: begin
          nb_d = {blk_q, bus_io.rx_data};
          st_d = StData;
        end
        StData: begin
          cnt_d = cnt_q + 9'd1;
          if (bus_io.fifo_full) err_d[1] = 1'b1;
          else                  wreq_d   = 1'b1;
          if (cnt_d == 9'd256) st_d = StDrain;
        end
        StDrain: st_d = StDrain;
        default: st_d = StIdle;
      endcase
      // Frame ended while still expecting header, count or page bytes.
      if (bus_io.rx_last) begin
        if (st_d inside {StH1, StH2, StCmd, StBlk0, StBlk1, StBlk2, StBlk3, StData}) begin
          err_d[2] = 1'b1;
        end
        st_d = StIdle;
      end
    end
  end

  assign src_level = code_q[0] ? bus_io.erase_done : bus_io.send_more;

  always_comb begin
    r_d    = r_q;
    code_d = code_q;
    case (r_q)
      RIdle: begin
        if (bus_io.erase_done) begin
          code_d = 2'b01;
          r_d    = RReq;
        end else if (bus_io.send_more) begin
          code_d = 2'b10;
          r_d    = RReq;
        end
      end
      RReq:    if (bus_io.reply_ack) r_d = RAck;
      RAck:    if (!src_level) r_d = RIdle;
      default: r_d = RIdle;
    endcase
  end

  assign bus_io.fifo_wreq      = wreq_q;
  assign bus_io.fifo_wdata     = wdata_q;
  assign bus_io.erase          = erase_q;
  assign bus_io.num_blocks     = nb_q;
  assign bus_io.err_flags      = err_q;
  assign bus_io.reply_req      = (r_q == RReq);
  assign bus_io.reply_code     = (r_q == RReq) ? code_q : 2'b00;
  assign bus_io.erase_done_ACK = (r_q == RAck) && code_q[0];
  assign bus_io.send_more_ACK  = (r_q == RAck) && code_q[1];

endmodule

// File: tb/tb_asmi_prog_rx.sv
// Bench for asmi_prog_rx: directed and random frames scored against a frame-level model,
// plus directed checks of the reply handshake.
module tb_asmi_prog_rx;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  asmi_prog_rx_if bus ();
  asmi_prog_rx dut (.clock(clock), .reset_n(reset_n), .bus_io(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0]  frm[$];
  logic [7:0]  got[$];
  logic [7:0]  m_exp[$];
  logic [2:0]  m_err;
  logic [13:0] m_nb;
  logic        m_erase;

  always @(negedge clock) if (bus.fifo_wreq) got.push_back(bus.fifo_wdata);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-frame model: the effect of one frame on writes, flags, block count and erase.
  task automatic model_frame(input int full_lo, input int full_hi);
    int n = frm.size();
    logic [7:0] hdr [3] = '{8'hEF, 8'hFE, 8'h03};
    for (int k = 0; k < 3; k++) begin
      if (frm[k] !== hdr[k]) begin m_err[0] = 1'b1; return; end
      if (k == n - 1) begin m_err[2] = 1'b1; return; end
    end
    if (frm[3] == 8'h02) begin
      if (!m_erase) begin m_erase = 1'b1; m_err = 3'b000; end
      return;
    end
    if (frm[3] != 8'h01) begin m_err[0] = 1'b1; return; end
    if (n < 264) m_err[2] = 1'b1;
    if (n >= 8) m_nb = {frm[6][5:0], frm[7]};
    for (int j = 8; j < n && j < 264; j++) begin
      if (j >= full_lo && j <= full_hi) m_err[1] = 1'b1;
      else m_exp.push_back(frm[j]);
    end
  endtask

  task automatic drive(input int from, input int to, input bit last, input int full_lo,
                       input int full_hi, input bit echk);
    for (int i = from; i <= to; i++) begin
      @(negedge clock);
      if (echk && i == 3) chk("erase_before_cmd", bus.erase, 1'b0);
      if (echk && i == 4) chk("erase_rise", bus.erase, 1'b1);
      bus.rx_valid  = 1'b1;
      bus.rx_data   = frm[i];
      bus.rx_last   = last && (i == to);
      bus.fifo_full = (i >= full_lo) && (i <= full_hi);
    end
    @(negedge clock);
    bus.rx_valid  = 1'b0;
    bus.rx_last   = 1'b0;
    bus.fifo_full = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_frame(input string tag, input int full_lo, input int full_hi);
    bit echk;
    int first_bad = -1;
    echk = !m_erase && frm.size() > 4 && frm[0] == 8'hEF && frm[1] == 8'hFE &&
           frm[2] == 8'h03 && frm[3] == 8'h02;
    got.delete();
    m_exp.delete();
    model_frame(full_lo, full_hi);
    drive(0, frm.size() - 1, 1'b1, full_lo, full_hi, echk);
    chk({tag, "_nwr"}, got.size(), m_exp.size());
    for (int i = 0; i < m_exp.size() && i < got.size(); i++) begin
      if (first_bad < 0 && got[i] !== m_exp[i]) first_bad = i;
    end
    chk({tag, "_data_first_bad_idx"}, first_bad, -1);
    chk({tag, "_err"}, bus.err_flags, m_err);
    chk({tag, "_nblk"}, bus.num_blocks, m_nb);
    chk({tag, "_erase"}, bus.erase, m_erase);
  endtask

  task automatic ack_erase();
    @(negedge clock);
    bus.erase_ACK = 1'b1;
    @(negedge clock);
    bus.erase_ACK = 1'b0;
    chk("erase_fall", bus.erase, 1'b0);
    m_erase = 1'b0;
  endtask

  task automatic build_prog(input logic [31:0] blocks, input int ndata, input int npad,
                            input bit seq);
    frm.delete();
    frm.push_back(8'hEF); frm.push_back(8'hFE); frm.push_back(8'h03); frm.push_back(8'h01);
    frm.push_back(blocks[31:24]); frm.push_back(blocks[23:16]);
    frm.push_back(blocks[15:8]);  frm.push_back(blocks[7:0]);
    for (int i = 0; i < ndata; i++) frm.push_back(seq ? 8'(i) : 8'($urandom));
    for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
  endtask

  task automatic build_erase(input int npad);
    frm.delete();
    frm.push_back(8'hEF); frm.push_back(8'hFE); frm.push_back(8'h03); frm.push_back(8'h02);
    for (int i = 0; i < npad; i++) frm.push_back(8'($urandom));
  endtask

  initial begin
    int kind, lo, hi, idx;
    bus.rx_data = '0; bus.rx_valid = 0; bus.rx_last = 0; bus.fifo_full = 0;
    bus.erase_ACK = 0; bus.erase_done = 0; bus.send_more = 0; bus.reply_ack = 0;
    m_err = '0; m_nb = '0; m_erase = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_wreq", bus.fifo_wreq, 1'b0);
    chk("rst_erase", bus.erase, 1'b0);
    chk("rst_nblk", bus.num_blocks, 14'd0);
    chk("rst_err", bus.err_flags, 3'b000);
    chk("rst_reply", {bus.reply_req, bus.reply_code, bus.erase_done_ACK, bus.send_more_ACK}, 0);
    reset_n = 1'b1;

    // Erase frame with 60 pad bytes; erase held until acknowledged.
    build_erase(60);
    run_frame("erase1", 1000, -1);
    repeat (3) @(negedge clock);
    chk("erase_hold", bus.erase, 1'b1);
    ack_erase();

    build_prog(32'h200, 256, 5, 1'b1);
    run_frame("prog_seq", 1000, -1);
    build_prog(32'h200, 256, 5, 1'b1);
    run_frame("prog_full", 18, 27);
    build_prog(32'h200, 256, 0, 1'b1);
    frm[1] = 8'hFF;
    frm = frm[0:9];
    run_frame("bad_hdr", 1000, -1);
    build_prog(32'hFFFF_C123, 256, 2, 1'b0);
    run_frame("after_bad", 1000, -1);
    build_erase(3);
    run_frame("erase_clr", 1000, -1);
    ack_erase();
    build_prog(32'h0000_0044, 100, 0, 1'b0);
    run_frame("short100", 1000, -1);
    build_prog(32'h0000_0007, 256, 1, 1'b0);
    run_frame("after_short", 1000, -1);

    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 3);
      lo = 8 + $urandom_range(0, 255);
      hi = ($urandom_range(0, 1) == 1) ? lo + $urandom_range(0, 20) : lo - 1;
      case (kind)
        0: build_prog($urandom, 256, $urandom_range(0, 8), 1'b0);
        1: build_prog($urandom, $urandom_range(0, 255), 0, 1'b0);
        2: build_erase($urandom_range(1, 10));
        default: begin
          build_prog($urandom, 20, 0, 1'b0);
          idx = $urandom_range(0, 3);
          if (idx < 3) frm[idx] = frm[idx] ^ 8'($urandom_range(1, 255));
          else frm[3] = 8'h10 | 8'($urandom);
        end
      endcase
      run_frame($sformatf("rand%0d", it), lo, hi);
      if (m_erase && $urandom_range(0, 1) == 1) ack_erase();
    end

    // Reset in the middle of a page: the rest of the frame is parsed as a new frame.
    build_prog(32'h5, 256, 0, 1'b1);
    drive(0, 30, 1'b0, 1000, -1, 1'b0);
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    m_err = '0; m_nb = '0; m_erase = 0;
    chk("midrst_err", bus.err_flags, 3'b000);
    chk("midrst_nblk", bus.num_blocks, 14'd0);
    for (int i = 0; i < 31; i++) void'(frm.pop_front());
    run_frame("midrst_rest", 1000, -1);

    // Reply handshake: erase_done wins over send_more.
    @(negedge clock);
    bus.erase_done = 1'b1; bus.send_more = 1'b1;
    @(negedge clock);
    chk("rep1_req", bus.reply_req, 1'b1);
    chk("rep1_code", bus.reply_code, 2'b01);
    repeat (3) @(negedge clock);
    chk("rep1_req_hold", bus.reply_req, 1'b1);
    chk("rep1_ack_early", bus.erase_done_ACK, 1'b0);
    bus.reply_ack = 1'b1;
    @(negedge clock);
    bus.reply_ack = 1'b0;
    chk("rep1_req_drop", bus.reply_req, 1'b0);
    chk("rep1_edack", bus.erase_done_ACK, 1'b1);
    chk("rep1_smack", bus.send_more_ACK, 1'b0);
    repeat (2) @(negedge clock);
    chk("rep1_edack_hold", bus.erase_done_ACK, 1'b1);
    bus.erase_done = 1'b0;
    @(negedge clock);
    chk("rep1_edack_drop", bus.erase_done_ACK, 1'b0);
    chk("rep1_req_idle", bus.reply_req, 1'b0);
    @(negedge clock);
    chk("rep2_req", bus.reply_req, 1'b1);
    chk("rep2_code", bus.reply_code, 2'b10);
    bus.reply_ack = 1'b1;
    @(negedge clock);
    bus.reply_ack = 1'b0;
    chk("rep2_smack", bus.send_more_ACK, 1'b1);
    bus.send_more = 1'b0;
    @(negedge clock);
    chk("rep2_smack_drop", bus.send_more_ACK, 1'b0);
    @(negedge clock);
    chk("rep2_idle", bus.reply_req, 1'b0);

    // Source level withdrawn while the request is outstanding.
    bus.send_more = 1'b1;
    @(negedge clock);
    chk("rep3_req", bus.reply_req, 1'b1);
    bus.send_more = 1'b0;
    @(negedge clock);
    chk("rep3_req_hold", bus.reply_req, 1'b1);
    bus.reply_ack = 1'b1;
    @(negedge clock);
    bus.reply_ack = 1'b0;
    chk("rep3_smack", bus.send_more_ACK, 1'b1);
    @(negedge clock);
    chk("rep3_smack_drop", bus.send_more_ACK, 1'b0);
    chk("rep3_req_idle", bus.reply_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
